// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback stage: default widths and load encodings.
package wb_unit_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int RFIDX_WIDTH_DEF = 5;

  // Load funct3 encodings as seen on the LSU response.
  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_op_e;

endpackage

// File: rtl/wb_unit_load_fmt.sv
// Load result formatter: picks the byte/half addressed by addr_lo and extends it.
// Purely combinational so a future forwarding path can reuse it.
module load_fmt
  import wb_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction then extension by load type; unknown types act as LW.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    // addr_lo[0] is ignored: the LSU only issues aligned halfwords.
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      LOAD_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LOAD_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LOAD_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
      LOAD_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: sole driver of the register file write port. Merges
// backpressure-free ALU results with queued load responses, and stalls the
// ALU when a load has waited too long at the queue head.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int RFIDX_WIDTH  = RFIDX_WIDTH_DEF,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [RFIDX_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  output logic                   alu_stall,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic [2:0]             lsu_funct3,
  input  logic [1:0]             lsu_addr_lo,
  output logic                   reg_write,
  output logic [RFIDX_WIDTH-1:0] write_addr,
  output logic [XLEN-1:0]        write_data,
  output logic                   wb_busy
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  // Load queue storage, one array per field.
  logic [RFIDX_WIDTH-1:0] q_rd     [LQ_DEPTH];
  logic [XLEN-1:0]        q_data   [LQ_DEPTH];
  logic [2:0]             q_funct3 [LQ_DEPTH];
  logic [1:0]             q_addr   [LQ_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [AGE_W-1:0] age;

  logic             q_nonempty;
  logic             push, pop, alu_sel;
  logic [XLEN-1:0]  head_fmt;

  assign q_nonempty = (count != '0);
  assign wb_busy    = q_nonempty;
  // Readiness depends on occupancy only; a same-cycle pop does not make room.
  assign lsu_ready  = !rst && (count != CNT_W'(LQ_DEPTH));
  assign alu_stall  = !rst && q_nonempty && (age >= AGE_W'(STARVE_LIMIT));
  assign push       = lsu_valid && lsu_ready;
  // ALU has priority unless the starvation guard fires; loads fill idle slots.
  assign alu_sel    = alu_valid && !alu_stall;
  assign pop        = !rst && !alu_sel && q_nonempty;

  load_fmt #(.XLEN(XLEN)) u_fmt (
    .data    (q_data[rd_ptr]),
    .funct3  (q_funct3[rd_ptr]),
    .addr_lo (q_addr[rd_ptr]),
    .result  (head_fmt)
  );

  // Queue payload; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]     <= lsu_rd;
      q_data[wr_ptr]   <= lsu_data;
      q_funct3[wr_ptr] <= lsu_funct3;
      q_addr[wr_ptr]   <= lsu_addr_lo;
    end
  end

  // Queue pointers and occupancy; pointers wrap since depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head age: counts cycles the head waits, saturating at the stall threshold.
  always_ff @(posedge clk) begin
    if (rst || pop || !q_nonempty)
      age <= '0;
    else if (age < AGE_W'(STARVE_LIMIT))
      age <= age + 1'b1;
  end

  // Registered write port; x0 targets are consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else if (alu_sel) begin
      reg_write <= (alu_rd != '0);
      if (alu_rd != '0) begin
        write_addr <= alu_rd;
        write_data <= alu_data;
      end
    end else if (pop) begin
      reg_write <= (q_rd[rd_ptr] != '0);
      if (q_rd[rd_ptr] != '0) begin
        write_addr <= q_rd[rd_ptr];
        write_data <= head_fmt;
      end
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: reset, ALU path, load formatting, x0, queue
// ordering under ALU pressure, starvation guard and mid-flight reset.
module tb_wb_unit;
  import wb_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        wb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_unit #(.XLEN(32), .RFIDX_WIDTH(5), .LQ_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
    .wb_busy(wb_busy)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    lsu_funct3 = LOAD_LW; lsu_addr_lo = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", reg_write); end
      checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready: got %b want 0", lsu_ready); end
      checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_alu_stall: got %b want 0", alu_stall); end
      checks++; if (write_addr !== 5'd0 || write_data !== 32'd0) begin errors++; $display("FAIL reset_write_port: got %0d/%h want 0/0", write_addr, write_data); end
      checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL reset_wb_busy: got %b want 0", wb_busy); end
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL alu_lsu_ready_after_reset: got %b want 1", lsu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write: got we=%b rd=%0d data=%h want 1/5/deadbeef", reg_write, write_addr, write_data); end
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL alu_idle: got we=%b want 0", reg_write); end
    checks++; if (write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_hold: got %0d/%h want 5/deadbeef", write_addr, write_data); end
  endtask

  task automatic test_load_fmt();
    logic [2:0]  f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b011};
    logic [1:0]  alo [8] = '{2'd0,   2'd2,   2'd2,   2'd0,   2'd0,   2'd3,   2'd1,   2'd1};
    logic [31:0] exp [8] = '{32'hFFFFFFF7, 32'h00000081, 32'hFFFF8081, 32'h0000F0F7,
                             32'h8081F0F7, 32'hFFFFFF80, 32'h000000F0, 32'h8081F0F7};
    for (int i = 0; i < 8; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h8081F0F7;
      lsu_funct3 = f3[i]; lsu_addr_lo = alo[i];
      step();
      lsu_valid = 1'b0;
      checks++; if (reg_write !== 1'b0 || wb_busy !== 1'b1) begin
        errors++; $display("FAIL load_no_bypass[%0d]: got we=%b busy=%b want 0/1", i, reg_write, wb_busy); end
      step();
      checks++; if (reg_write !== 1'b1 || write_addr !== 5'd3 || write_data !== exp[i]) begin
        errors++; $display("FAIL load_fmt[%0d]: got we=%b rd=%0d data=%h want 1/3/%h", i, reg_write, write_addr, write_data, exp[i]); end
      checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL load_drain[%0d]: got busy=%b want 0", i, wb_busy); end
    end
    step();
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    step();
    alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL x0_alu: got we=%b want 0", reg_write); end
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55AA55AA; lsu_funct3 = LOAD_LW; lsu_addr_lo = '0;
    step();
    lsu_valid = 1'b0;
    checks++; if (wb_busy !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL x0_load_queued: got busy=%b we=%b want 1/0", wb_busy, reg_write); end
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL x0_load: got we=%b want 0", reg_write); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", wb_busy); end
  endtask

  task automatic test_queue_full();
    int  next_ld = 1;
    int  got = 0;
    logic hs;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      lsu_valid = (next_ld <= 3); lsu_rd = 5'(next_ld);
      lsu_data = 32'h100 + 32'(next_ld); lsu_funct3 = LOAD_LW; lsu_addr_lo = '0;
      #1;
      if (cyc == 2) begin
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL qfull_ready_drop: got %b want 0", lsu_ready); end
      end
      hs = lsu_valid && lsu_ready;
      step();
      if (hs) next_ld++;
      if (reg_write === 1'b1 && write_addr !== 5'd7) begin
        checks++;
        if (write_addr !== 5'(got + 1) || write_data !== 32'h100 + 32'(got + 1)) begin
          errors++; $display("FAIL qfull_order: got rd=%0d data=%h want %0d/%h", write_addr, write_data, got + 1, 32'h100 + 32'(got + 1)); end
        got++;
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL qfull_timeout: got %0d loads want 3", got); end
    idle_inputs();
    step(); step();
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL qfull_empty: got busy=%b want 0", wb_busy); end
  endtask

  task automatic test_starvation();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'hCAFE0009; lsu_funct3 = LOAD_LW; lsu_addr_lo = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      lsu_valid = 1'b0;
      checks++; if (reg_write !== 1'b1 || write_addr !== 5'd10 || write_data !== 32'hA0 + 32'(k)) begin
        errors++; $display("FAIL starve_alu[%0d]: got we=%b rd=%0d data=%h want 1/10/%h", k, reg_write, write_addr, write_data, 32'hA0 + 32'(k)); end
      checks++; if (alu_stall !== (k == 4)) begin
        errors++; $display("FAIL starve_stall[%0d]: got %b want %b", k, alu_stall, (k == 4)); end
      if (k < 4) alu_data = 32'hA0 + 32'(k + 1);
    end
    step();
    checks++; if (reg_write !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'hCAFE0009) begin
      errors++; $display("FAIL starve_load: got we=%b rd=%0d data=%h want 1/9/cafe0009", reg_write, write_addr, write_data); end
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", alu_stall); end
    step();
    alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || write_addr !== 5'd10 || write_data !== 32'hA4) begin
      errors++; $display("FAIL starve_held_alu: got we=%b rd=%0d data=%h want 1/10/a4", reg_write, write_addr, write_data); end
    step();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h12; lsu_funct3 = LOAD_LW; lsu_addr_lo = '0;
    step();
    lsu_rd = 5'd13; lsu_data = 32'h13;
    step();
    checks++; if (wb_busy !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_queued: got busy=%b ready=%b want 1/0", wb_busy, lsu_ready); end
    idle_inputs();
    rst = 1'b1;
    step();
    checks++; if (reg_write !== 1'b0 || wb_busy !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_reset: got we=%b busy=%b ready=%b want 0/0/0", reg_write, wb_busy, lsu_ready); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (reg_write !== 1'b0 || wb_busy !== 1'b0) begin
        errors++; $display("FAIL rmid_after[%0d]: got we=%b busy=%b want 0/0", i, reg_write, wb_busy); end
    end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", lsu_ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_fmt();
    test_x0();
    test_queue_full();
    test_starvation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback stage: the sole driver of the register file write port (reg_write / write_addr / write_data).
- Merges two result sources:
  - ALU results, which arrive with no backpressure.
  - Load responses from the LSU, which arrive through a valid/ready handshake.
- Loads are buffered in a small in-order queue and formatted per funct3 (byte/half extraction, sign/zero extension) before the write.
- A starvation guard stalls the ALU pipeline so that pending loads always retire.

Parameters:
- XLEN, 32, data width (same value as `XLEN in defines.v).
- RFIDX_WIDTH, 5, register index width (same value as `RFIDX_WIDTH).
- LQ_DEPTH, 2, load queue entries (power of two, ≥2).
- STARVE_LIMIT, 4, cycles a load may sit at the queue head before the ALU is stalled.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  RFIDX_WIDTH  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_stall  out  1  ALU result not accepted; pipeline holds alu_* stable.
- lsu_valid  in  1  load response valid.
- lsu_ready  out  1  queue can accept a response.
- lsu_rd  in  RFIDX_WIDTH  load destination register.
- lsu_data  in  XLEN  raw aligned memory word.
- lsu_funct3  in  3  load type.
- lsu_addr_lo  in  2  byte offset within the word.
- reg_write  out  1  register file write enable (registered).
- write_addr  out  RFIDX_WIDTH  register file write index (registered).
- write_data  out  XLEN  register file write data (registered).
- wb_busy  out  1  load queue non-empty.

Behaviour:
- Reset (rst=1 at posedge):
  - reg_write=0, write_addr=0, write_data=0.
  - Queue empty (count=0, pointers 0); age counter 0.
  - lsu_ready=0 and alu_stall=0 while rst is high.
  - rst overrides any in-flight push or pop; queued loads are discarded.
- Queue:
  - FIFO of {rd, data, funct3, addr_lo}.
  - Push on lsu_valid && lsu_ready.
  - lsu_ready = (count != LQ_DEPTH), computed from count only; a same-cycle pop does not make room.
  - Pointers wrap modulo LQ_DEPTH.
- Age counter:
  - Increments each cycle the queue is non-empty and no pop occurs.
  - Clears on pop or when the queue is empty.
  - Saturates at STARVE_LIMIT.
- alu_stall = !rst && (count != 0) && (age >= STARVE_LIMIT); combinational.
- Selection each cycle:
  - alu_valid && !alu_stall: write ALU result.
  - Otherwise, if count != 0: pop the head, format it, and write it.
  - Otherwise: reg_write=0 next cycle (write_addr/write_data hold their last values).
- Latency:
  - ALU: result visible on the write port 1 cycle after acceptance.
  - Load: enters the queue at edge N, earliest write visible after edge N+1 (2 cycles). There is no bypass of an empty queue.
- x0 suppression: a selected entry with rd==0 is consumed (ALU accepted or load popped), but reg_write=0 for it.
- Load formatting (funct3):
  - 000 LB: byte at lsu_addr_lo, sign-extended.
  - 001 LH: half at lsu_addr_lo[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - Any other funct3: treated as LW.
  - lsu_addr_lo[0] is ignored for halfwords; the LSU guarantees alignment.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; data ordering is preserved.
  - Push into a full queue is impossible, because lsu_ready=0.
- Write/read hazard: none is handled here. The register file writes on posedge and reads on negedge, so a written value is readable in the same cycle it commits.

Decomposition:
- The shared defines file holds:
  - `XLEN and `RFIDX_WIDTH.
  - Load funct3 encodings: LOAD_LB=3'b000, LOAD_LH=3'b001, LOAD_LW=3'b010, LOAD_LBU=3'b100, LOAD_LHU=3'b101.
- Sub-module load_fmt: purely combinational (data, funct3, addr_lo) -> XLEN result. It is unit-testable on its own and reusable by a later forwarding path.
- Queue, age counter and selection logic stay in wb_unit.

Test Plan:
- Reset and ALU path:
  - Stimulus: rst 2 cycles, then alu_valid=1, rd=5, data=0xDEADBEEF.
  - Required: reg_write=0 and lsu_ready=0 during reset; one cycle after acceptance, reg_write=1, write_addr=5, write_data=0xDEADBEEF.
- Load formatting, with lsu_data=0x8081F0F7 and rd=3:
  - LB, addr_lo=0 -> 0xFFFFFFF7.
  - LBU, addr_lo=2 -> 0x00000081.
  - LH, addr_lo=2 -> 0xFFFF8081.
  - LHU, addr_lo=0 -> 0x0000F0F7.
  - LW -> 0x8081F0F7.
  - Each write appears 2 cycles after the push.
- x0 writes:
  - Stimulus: ALU rd=0, data=0x1234, then a load with rd=0.
  - Required: both are consumed, reg_write stays 0, and wb_busy returns to 0.
- Queue full and ordering:
  - Stimulus: alu_valid held 1 (non-zero rd) while 3 loads (rd=1,2,3) are offered back to back.
  - Required: lsu_ready drops after 2 pushes; the loads retire in order 1,2,3.
- Starvation:
  - Stimulus: continuous alu_valid with one queued load.
  - Required:
    - alu_stall asserts once age reaches 4.
    - The load writes in the following cycle; alu_stall then deasserts.
    - The held ALU result writes in the cycle after that.
- Reset mid-operation:
  - Stimulus: 2 loads queued, rst asserted for 1 cycle.
  - Required: queue empty (wb_busy=0), no write of the queued loads, reg_write=0.
